// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants for the writeback stage
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT  = 4'h0;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  // Status encodings
  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  // Register identifiers
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] REG_RSP  = 4'h4;

  localparam int NUM_REGS = 15;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - 15x64 register storage, two write ports, flattened read bus
import y86_pkg::*;

module regfile_bank #(
  parameter int          NREGS    = NUM_REGS,
  parameter logic [63:0] RSP_INIT = 64'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_e,
  input  logic [3:0]            dst_e,
  input  logic [63:0]           val_e,
  input  logic                  we_m,
  input  logic [3:0]            dst_m,
  input  logic [63:0]           val_m,
  output logic [64*NREGS-1:0]   bus
);

  logic [63:0] mem [NREGS];

  // Storage: M port overrides E port when both target the same register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        mem[r] <= (4'(r) == REG_RSP) ? RSP_INIT : 64'h0;
      end
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (we_m && dst_m == 4'(r)) begin
          mem[r] <= val_m;
        end else if (we_e && dst_e == 4'(r)) begin
          mem[r] <= val_e;
        end
      end
    end
  end

  // Flatten storage onto the decode read bus
  always_comb begin
    bus = '0;
    for (int r = 0; r < NREGS; r++) begin
      bus[64*r +: 64] = mem[r];
    end
  end

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - SEQ writeback stage: commit, halt FSM, status, retire count (opt. WB_BYPASS_EN)
import y86_pkg::*;

module writeback_regfile #(
  parameter int          NREGS    = NUM_REGS,
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  wb_valid,
  input  logic [3:0]            icode,
  input  logic                  Cnd,
  input  logic [1:0]            stat,
  input  logic [3:0]            dstE,
  input  logic [3:0]            dstM,
  input  logic [63:0]           valE,
  input  logic [63:0]           valM,
  output logic [64*NREGS-1:0]   regis,
  output logic                  halted,
  output logic [1:0]            stat_out,
  output logic [CNT_W-1:0]      retired
);

  wb_state_t state, state_next;

  logic                  running;
  logic                  retire;
  logic                  halt_ev;
  logic                  we_e;
  logic                  we_m;
  logic [64*NREGS-1:0]   bank_bus;

  // Qualify commit and write enables; a halt instruction retires without writing
  always_comb begin
    running = (state == ST_RUN) && wb_valid;
    retire  = running && (stat == STAT_AOK);
    halt_ev = running && ((stat != STAT_AOK) || (icode == I_HALT));
    we_e    = retire && (icode != I_HALT) && (dstE != REG_NONE)
              && !((icode == I_CMOV) && !Cnd);
    we_m    = retire && (icode != I_HALT) && (dstM != REG_NONE);
  end

  regfile_bank #(
    .NREGS    (NREGS),
    .RSP_INIT (RSP_INIT)
  ) u_bank (
    .clk   (Clk),
    .rst_n (Rst_n),
    .we_e  (we_e),
    .dst_e (dstE),
    .val_e (valE),
    .we_m  (we_m),
    .dst_m (dstM),
    .val_m (valM),
    .bus   (bank_bus)
  );

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: HALT is entered on a fault or halt instruction and held until reset
  always_comb begin
    state_next = state;
    if (state == ST_RUN && halt_ev) begin
      state_next = ST_HALT;
    end
  end

  assign halted = (state == ST_HALT);

  // Status latch: captured once on the RUN to HALT transition
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stat_out <= STAT_AOK;
    end else if (halt_ev) begin
      stat_out <= (stat == STAT_AOK) ? STAT_HLT : stat;
    end
  end

  // Retired-instruction counter, saturating at all-ones
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      retired <= '0;
    end else if (retire && (retired != {CNT_W{1'b1}})) begin
      retired <= retired + CNT_W'(1);
    end
  end

`ifdef WB_BYPASS_EN
  // Write-through view so a same-cycle decode read sees the pending result
  always_comb begin
    regis = bank_bus;
    for (int r = 0; r < NREGS; r++) begin
      if (we_m && dstM == 4'(r)) begin
        regis[64*r +: 64] = valM;
      end else if (we_e && dstE == 4'(r)) begin
        regis[64*r +: 64] = valE;
      end
    end
  end
`else
  assign regis = bank_bus;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - table-driven self-checking bench for writeback_regfile
module tb_writeback_regfile;

  localparam logic [63:0] RSP_INIT = 64'h0;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          wb_valid;
  logic [3:0]    icode;
  logic          Cnd;
  logic [1:0]    stat;
  logic [3:0]    dstE;
  logic [3:0]    dstM;
  logic [63:0]   valE;
  logic [63:0]   valM;
  logic [959:0]  regis;
  logic          halted;
  logic [1:0]    stat_out;
  logic [31:0]   retired;

  int total = 0;
  int bad   = 0;

  writeback_regfile #(
    .NREGS    (15),
    .RSP_INIT (RSP_INIT),
    .CNT_W    (32)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .wb_valid (wb_valid),
    .icode    (icode),
    .Cnd      (Cnd),
    .stat     (stat),
    .dstE     (dstE),
    .dstM     (dstM),
    .valE     (valE),
    .valM     (valM),
    .regis    (regis),
    .halted   (halted),
    .stat_out (stat_out),
    .retired  (retired)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        v;
    logic [3:0]  ic;
    logic        c;
    logic [1:0]  st;
    logic [3:0]  de;
    logic [3:0]  dm;
    logic [63:0] ve;
    logic [63:0] vm;
    int          reg_idx;
    logic [63:0] exp_reg;
    logic        exp_halt;
    logic [1:0]  exp_stat;
    logic [31:0] exp_ret;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [63:0] rd(input int r);
    return regis[64*r +: 64];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic c, input logic [1:0] st,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm);
    wb_valid = v; icode = ic; Cnd = c; stat = st;
    dstE = de; dstM = dm; valE = ve; valM = vm;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'h3, 1'b0, 2'd0, 4'd2,  4'hF, 64'h1234, 64'h0,    2,  64'h1234, 1'b0, 2'd0, 32'd1};
    vecs[1]  = '{1'b1, 4'h2, 1'b0, 2'd0, 4'd3,  4'hF, 64'h5,    64'h0,    3,  64'h0,    1'b0, 2'd0, 32'd2};
    vecs[2]  = '{1'b1, 4'h2, 1'b1, 2'd0, 4'd3,  4'hF, 64'h5,    64'h0,    3,  64'h5,    1'b0, 2'd0, 32'd3};
    vecs[3]  = '{1'b1, 4'hB, 1'b0, 2'd0, 4'd4,  4'd4, 64'h108,  64'hABCD, 4,  64'hABCD, 1'b0, 2'd0, 32'd4};
    vecs[4]  = '{1'b0, 4'h3, 1'b0, 2'd0, 4'd5,  4'hF, 64'h77,   64'h0,    5,  64'h0,    1'b0, 2'd0, 32'd4};
    vecs[5]  = '{1'b1, 4'h6, 1'b0, 2'd0, 4'd7,  4'hF, 64'h99,   64'h0,    7,  64'h99,   1'b0, 2'd0, 32'd5};
    vecs[6]  = '{1'b1, 4'h5, 1'b0, 2'd0, 4'hF,  4'd8, 64'h11,   64'h55,   8,  64'h55,   1'b0, 2'd0, 32'd6};
    vecs[7]  = '{1'b1, 4'h8, 1'b0, 2'd0, 4'd4,  4'hF, 64'hF0,   64'h0,    4,  64'hF0,   1'b0, 2'd0, 32'd7};
    vecs[8]  = '{1'b1, 4'h4, 1'b0, 2'd0, 4'hF,  4'hF, 64'hEE,   64'hDD,   14, 64'h0,    1'b0, 2'd0, 32'd8};
    vecs[9]  = '{1'b1, 4'h3, 1'b0, 2'd2, 4'd1,  4'hF, 64'h9,    64'h0,    1,  64'h0,    1'b1, 2'd2, 32'd8};
    vecs[10] = '{1'b1, 4'h3, 1'b0, 2'd0, 4'd1,  4'hF, 64'h9,    64'h0,    1,  64'h0,    1'b1, 2'd2, 32'd8};

    Rst_n = 1'b0;
    drive(1'b0, 4'h1, 1'b0, 2'd0, 4'hF, 4'hF, 64'h0, 64'h0);
    repeat (2) @(negedge Clk);

    // Reset state
    for (int r = 0; r < 15; r++) begin
      chk($sformatf("reset_r%0d", r), rd(r), (r == 4) ? RSP_INIT : 64'h0);
    end
    chk("reset_halted", {63'h0, halted}, 64'h0);
    chk("reset_stat", {62'h0, stat_out}, 64'h0);
    chk("reset_retired", {32'h0, retired}, 64'h0);
    Rst_n = 1'b1;

    // Vector table: drive at negedge, commit at posedge, check at next negedge
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].ic, vecs[i].c, vecs[i].st, vecs[i].de, vecs[i].dm, vecs[i].ve, vecs[i].vm);
      @(negedge Clk);
      chk($sformatf("v%0d_reg", i), rd(vecs[i].reg_idx), vecs[i].exp_reg);
      chk($sformatf("v%0d_halted", i), {63'h0, halted}, {63'h0, vecs[i].exp_halt});
      chk($sformatf("v%0d_stat", i), {62'h0, stat_out}, {62'h0, vecs[i].exp_stat});
      chk($sformatf("v%0d_retired", i), {32'h0, retired}, {32'h0, vecs[i].exp_ret});
    end
    chk("halt_r2_kept", rd(2), 64'h1234);

    // Asynchronous reset mid-cycle clears immediately
    #2 Rst_n = 1'b0;
    #1;
    chk("areset_r2", rd(2), 64'h0);
    chk("areset_r4", rd(4), RSP_INIT);
    chk("areset_r8", rd(8), 64'h0);
    chk("areset_halted", {63'h0, halted}, 64'h0);
    chk("areset_stat", {62'h0, stat_out}, 64'h0);
    chk("areset_retired", {32'h0, retired}, 64'h0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Same-cycle visibility before the edge depends on the bypass build
    drive(1'b1, 4'h3, 1'b0, 2'd0, 4'd6, 4'hF, 64'h66, 64'h0);
    #1;
`ifdef WB_BYPASS_EN
    chk("bypass_r6_pre_edge", rd(6), 64'h66);
`else
    chk("nobypass_r6_pre_edge", rd(6), 64'h0);
`endif
    @(negedge Clk);
    chk("r6_post_edge", rd(6), 64'h66);
    chk("r6_retired", {32'h0, retired}, 64'h1);

    // Halt instruction: retires once, writes nothing, latches HLT
    drive(1'b1, 4'h0, 1'b0, 2'd0, 4'd6, 4'hF, 64'h77, 64'h0);
    @(negedge Clk);
    chk("hlt_halted", {63'h0, halted}, 64'h1);
    chk("hlt_stat", {62'h0, stat_out}, 64'h1);
    chk("hlt_retired", {32'h0, retired}, 64'h2);
    chk("hlt_r6", rd(6), 64'h66);

    // Further activity after halt is ignored
    drive(1'b1, 4'h3, 1'b0, 2'd3, 4'd6, 4'hF, 64'h88, 64'h0);
    @(negedge Clk);
    drive(1'b1, 4'h3, 1'b0, 2'd0, 4'd6, 4'hF, 64'h88, 64'h0);
    @(negedge Clk);
    chk("post_hlt_stat", {62'h0, stat_out}, 64'h1);
    chk("post_hlt_retired", {32'h0, retired}, 64'h2);
    chk("post_hlt_r6", rd(6), 64'h66);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Writeback stage and architectural register file of the SEQ Y86-64 processor, sitting directly downstream of execute/memory.
- Commits valE/valM to the 15 program registers. Holds the processor status (stat) and the halt condition.
- Drives the flattened 960-bit regis bus that decode reads.

Parameters:
- NREGS, 15, number of architectural registers (indices 0..14; index 15 = no register)
- RSP_INIT, 64'h0, reset value of register 4 (%rsp)
- CNT_W, 32, width of the retired-instruction counter

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- wb_valid  in  1  an instruction is presented for writeback this cycle
- icode  in  4  instruction code of the presented instruction
- Cnd  in  1  condition result from execute (used for cmovXX)
- stat  in  2  incoming status: 0 AOK, 1 HLT, 2 ADR, 3 INS
- dstE  in  4  destination for valE (15 = none)
- dstM  in  4  destination for valM (15 = none)
- valE  in  64  ALU result
- valM  in  64  memory read result
- regis  out  960  register r at bits [64r+63:64r], r = 0..14
- halted  out  1  processor stopped; no further writes
- stat_out  out  2  architectural status
- retired  out  CNT_W  count of committed instructions

Behaviour:
- Reset (Rst_n low, asynchronous, any time, including mid-operation):
  - Registers 0..14 go to 0, except register 4, which goes to RSP_INIT.
  - State goes to RUN; halted=0; stat_out=0 (AOK); retired=0.
  - Reset takes effect immediately and overrides any same-edge write.
- State machine with two states:
  - RUN → HALT on a rising edge where wb_valid=1 and either stat≠AOK, or stat=AOK and icode=0.
  - HALT is sticky until reset. In HALT, all inputs are ignored; registers, stat_out and retired are frozen.
  - halted=1 exactly when the state is HALT (registered output).
- Status latch on the RUN→HALT transition:
  - stat_out takes the incoming stat.
  - If stat=AOK and icode=0, stat_out becomes HLT (1).
- Commit conditions, evaluated at a rising edge in RUN with wb_valid=1 and stat=AOK:
  - weE = (dstE≠15) and not (icode=2 and Cnd=0). A cmov whose condition fails writes nothing.
  - weM = (dstM≠15).
  - If weE and weM and dstE=dstM: valM wins. The popq %rsp case requires this.
  - icode=0 with AOK retires as halt: no register writes, but retired increments.
- Faulting instructions (stat≠AOK): no register writes, retired does not increment.
- retired:
  - Increments by 1 on each rising edge in RUN with wb_valid=1 and stat=AOK.
  - Saturates at all-ones; it does not wrap.
- Latency:
  - Writes are visible on regis one cycle after the commit edge (registered).
  - Exception: see the optional feature.
- wb_valid=0: no state change of any kind.
- Out-of-range index: a destination of 15 is never written.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - regis is a combinational write-through view.
  - A register slice targeted by a qualifying weE/weM this cycle shows the pending value (valM takes priority on conflict) before the edge.
  - Lets a same-cycle decode read observe the result.
- Undefined:
  - regis is purely the registered state.
  - Writes appear the cycle after the commit edge.
- Architectural state, halted, stat_out and retired are identical in both builds.

Decomposition:
- Package y86_pkg holds:
  - icode constants (HALT=0, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, CALL=8, RET=9, PUSH=10, POP=11)
  - stat encodings (AOK, HLT, ADR, INS)
  - REG_NONE=4'hF, REG_RSP=4'h4
  - the register-count constant
- Sub-module regfile_bank contains:
  - the 15×64 storage with two write ports (E, M), M-port priority, async reset with RSP_INIT
  - the flattening to the 960-bit bus
- writeback_regfile contains:
  - write-enable qualification
  - the RUN/HALT state machine, stat latch, retired counter
  - the bypass mux

Test Plan:
- Reset, then read bus → regis all zero except bits [319:256] = RSP_INIT; halted=0, stat_out=0, retired=0.
- irmovq: wb_valid, icode=3, stat=AOK, dstE=2, valE=64'h1234, dstM=15 → regis[191:128]=64'h1234 next cycle; retired=1.
- cmov with Cnd=0, dstE=3, valE=5 → r3 unchanged, retired increments. Repeat with Cnd=1 → r3=5.
- popq %rsp: icode=11, dstE=4, valE=64'h108, dstM=4, valM=64'hABCD → r4=64'hABCD.
- stat=ADR with dstE=1, valE=9 → r1 unchanged, halted=1, stat_out=2, retired unchanged. Later AOK writes are ignored. Assert Rst_n low mid-cycle → immediate clear to the reset values.
- icode=0 with AOK → halted=1, stat_out=1, retired increments once. With WB_BYPASS_EN defined, a dstE=6 write shows on regis[447:384] in the same cycle, before the edge.
